// File: rtl/store_buffer_if.sv
`timescale 1ns/1ps
// Store buffer bus bundle: store request, load lookup and memory write port.
// Combinational signals only, no storage.
// The master drives requests; the slave (the buffer) returns status and memory strobes.
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic [1:0]    st_size;

  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [1:0]    ld_size;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          ld_conflict;

  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [1:0]    mem_data_size;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size,
    input  st_ready, fwd_hit, fwd_data, ld_conflict,
           mem_wr_en, mem_addr, mem_wr_data, mem_data_size, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, ld_valid, ld_addr, ld_size,
    output st_ready, fwd_hit, fwd_data, ld_conflict,
           mem_wr_en, mem_addr, mem_wr_data, mem_data_size, empty
  );
endinterface

// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// Posted-write FIFO with load forwarding between the load/store stage and data memory.
// Store to memory write: earliest one edge after acceptance; forwarding is combinational.
// st_ready = !full; drains only when no load owns the port or the load is in conflict.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [1:0]    size_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;

  logic          full, empty, push, pop, drain_ok;
  logic          hit, conflict;
  logic [DW-1:0] hit_data;
  logic [1:0]    hit_size;
  logic [PW-1:0] idx;
  logic [AW:0]   ld_lo, ld_hi, ent_lo, ent_hi;

  // Access size in bytes, widened so range ends never wrap.
  function automatic logic [AW:0] span(input logic [1:0] s);
    case (s)
      2'b00:   span = (AW+1)'(1);
      2'b01:   span = (AW+1)'(2);
      default: span = (AW+1)'(4);
    endcase
  endfunction

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = bus.st_valid & ~full & (bus.st_size != 2'b11);
  assign drain_ok = ~bus.ld_valid | conflict;
  assign pop      = ~empty & drain_ok;

  // Scan oldest to youngest so the youngest overlapping entry has the final say.
  always_comb begin
    hit      = 1'b0;
    conflict = 1'b0;
    hit_data = '0;
    hit_size = 2'b10;
    idx      = '0;
    ent_lo   = '0;
    ent_hi   = '0;
    ld_lo    = {1'b0, bus.ld_addr};
    ld_hi    = ld_lo + span(bus.ld_size) - (AW+1)'(1);
    for (int k = 0; k < DEPTH; k++) begin
      idx    = head_q + PW'(k);
      ent_lo = {1'b0, addr_q[idx]};
      ent_hi = ent_lo + span(size_q[idx]) - (AW+1)'(1);
      if (((PW+1)'(k) < count_q) && (ent_lo <= ld_hi) && (ld_lo <= ent_hi)) begin
        if ((ent_lo == ld_lo) && (size_q[idx] == bus.ld_size)) begin
          hit      = 1'b1;
          conflict = 1'b0;
          hit_data = data_q[idx];
          hit_size = size_q[idx];
        end else begin
          hit      = 1'b0;
          conflict = 1'b1;
        end
      end
    end
    if (!bus.ld_valid || (bus.ld_size == 2'b11)) begin
      hit      = 1'b0;
      conflict = 1'b0;
    end
  end

  // Sign-extend forwarded data the same way memory does; zero when nothing is forwarded.
  always_comb begin
    bus.fwd_data = '0;
    if (hit) begin
      case (hit_size)
        2'b00:   bus.fwd_data = {{(DW-8){hit_data[7]}}, hit_data[7:0]};
        2'b01:   bus.fwd_data = {{(DW-16){hit_data[15]}}, hit_data[15:0]};
        default: bus.fwd_data = hit_data;
      endcase
    end
  end

  assign bus.fwd_hit       = hit;
  assign bus.ld_conflict   = conflict;
  assign bus.st_ready      = ~full;
  assign bus.empty         = empty;
  assign bus.mem_wr_en     = pop;
  assign bus.mem_addr      = addr_q[head_q];
  assign bus.mem_wr_data   = data_q[head_q];
  assign bus.mem_data_size = size_q[head_q];

  // Entry storage and pointers; entries cleared on reset so the memory port reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q] <= bus.st_addr;
        data_q[tail_q] <= bus.st_data;
        size_q[tail_q] <= bus.st_size;
        tail_q         <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
// Directed bench for store_buffer: reset, drain, fill, forwarding, conflicts, ordering.
module tb_store_buffer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  store_buffer_if #(.AW(32), .DW(32)) bus ();

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = s;
  endtask

  task automatic set_load(input logic v, input logic [31:0] a, input logic [1:0] s);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_size  = s;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    set_load(1'b0, 32'h0, 2'b00);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_checks++; if (bus.st_ready !== 1'b1) begin n_fail++; $display("FAIL reset_st_ready: got %b want 1", bus.st_ready); end
    n_checks++; if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr_en: got %b want 0", bus.mem_wr_en); end
    n_checks++; if ({bus.fwd_hit, bus.ld_conflict} !== 2'b00) begin n_fail++; $display("FAIL reset_hit_conflict: got %b want 00", {bus.fwd_hit, bus.ld_conflict}); end
    n_checks++; if (bus.fwd_data !== 32'h0) begin n_fail++; $display("FAIL reset_fwd_data: got %h want 0", bus.fwd_data); end
    n_checks++; if ({bus.mem_addr, bus.mem_wr_data, bus.mem_data_size} !== 66'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h %h %b want zeros", bus.mem_addr, bus.mem_wr_data, bus.mem_data_size); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if ({bus.empty, bus.st_ready, bus.mem_wr_en} !== 3'b110) begin n_fail++; $display("FAIL idle_after_reset: got %b want 110", {bus.empty, bus.st_ready, bus.mem_wr_en}); end
  endtask

  task automatic test_push_drain;
    @(negedge clk);
    set_load(1'b0, 32'h0, 2'b00);
    set_store(1'b1, 32'h100, 32'hDEADBEEF, 2'b10);
    #1;
    n_checks++; if (bus.mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL push_not_same_cycle: got %b want 0", bus.mem_wr_en); end
    @(negedge clk);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    n_checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wr_data !== 32'hDEADBEEF || bus.mem_data_size !== 2'b10)
      begin n_fail++; $display("FAIL push_drain_write: got en=%b %h %h %b want 1 100 deadbeef 10", bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, bus.mem_data_size); end
    n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL push_drain_nonempty: got %b want 0", bus.empty); end
    @(negedge clk); #1;
    n_checks++; if ({bus.empty, bus.mem_wr_en} !== 2'b10) begin n_fail++; $display("FAIL push_drain_empty_after: got %b want 10", {bus.empty, bus.mem_wr_en}); end
  endtask

  task automatic test_fill;
    @(negedge clk);
    set_load(1'b1, 32'h900, 2'b10);
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h10 + 32'(4*i), 32'(i + 1), 2'b10);
      @(negedge clk);
    end
    #1;
    n_checks++; if (bus.st_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: st_ready got %b want 0", bus.st_ready); end
    n_checks++; if ({bus.mem_wr_en, bus.fwd_hit, bus.ld_conflict} !== 3'b000) begin n_fail++; $display("FAIL fill_load_blocks: got %b want 000", {bus.mem_wr_en, bus.fwd_hit, bus.ld_conflict}); end
    set_store(1'b1, 32'h20, 32'h5, 2'b10);
    @(negedge clk);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    set_load(1'b0, 32'h0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 32'h10 + 32'(4*i) || bus.mem_wr_data !== 32'(i + 1))
        begin n_fail++; $display("FAIL fill_drain_%0d: got en=%b %h %h want 1 %h %h", i, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data, 32'h10 + 32'(4*i), 32'(i + 1)); end
      @(negedge clk);
    end
    #1;
    n_checks++; if ({bus.empty, bus.mem_wr_en, bus.st_ready} !== 3'b101) begin n_fail++; $display("FAIL fill_fifth_ignored: got %b want 101", {bus.empty, bus.mem_wr_en, bus.st_ready}); end
  endtask

  task automatic test_illegal_size;
    @(negedge clk);
    set_load(1'b1, 32'h900, 2'b10);
    set_store(1'b1, 32'h40, 32'h55, 2'b11);
    @(negedge clk);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL illegal_size_ignored: empty got %b want 1", bus.empty); end
    set_load(1'b0, 32'h0, 2'b00);
  endtask

  task automatic test_forward;
    @(negedge clk);
    set_load(1'b1, 32'h200, 2'b00);
    set_store(1'b1, 32'h200, 32'h80, 2'b00);
    #1;
    n_checks++; if (bus.fwd_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_same_cycle_invisible: got %b want 0", bus.fwd_hit); end
    @(negedge clk);
    set_store(1'b1, 32'h204, 32'h7F01, 2'b01);
    #1;
    n_checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL fwd_byte_sext: got hit=%b %h want 1 ffffff80", bus.fwd_hit, bus.fwd_data); end
    n_checks++; if ({bus.ld_conflict, bus.mem_wr_en} !== 2'b00) begin n_fail++; $display("FAIL fwd_hit_no_drain: got %b want 00", {bus.ld_conflict, bus.mem_wr_en}); end
    @(negedge clk);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    set_load(1'b1, 32'h204, 2'b01);
    #1;
    n_checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h00007F01) begin n_fail++; $display("FAIL fwd_half: got hit=%b %h want 1 00007f01", bus.fwd_hit, bus.fwd_data); end
    set_load(1'b1, 32'h205, 2'b00);
    #1;
    n_checks++; if ({bus.fwd_hit, bus.ld_conflict, bus.mem_wr_en} !== 3'b011) begin n_fail++; $display("FAIL fwd_partial_half: got %b want 011", {bus.fwd_hit, bus.ld_conflict, bus.mem_wr_en}); end
    set_load(1'b1, 32'h200, 2'b11);
    #1;
    n_checks++; if ({bus.fwd_hit, bus.ld_conflict} !== 2'b00 || bus.fwd_data !== 32'h0) begin n_fail++; $display("FAIL fwd_illegal_ld_size: got %b %h want 00 0", {bus.fwd_hit, bus.ld_conflict}, bus.fwd_data); end
    set_load(1'b0, 32'h200, 2'b00);
    #1;
    n_checks++; if ({bus.fwd_hit, bus.mem_wr_en} !== 2'b01 || bus.fwd_data !== 32'h0) begin n_fail++; $display("FAIL fwd_no_ld_valid: got %b %h want 01 0", {bus.fwd_hit, bus.mem_wr_en}, bus.fwd_data); end
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL fwd_drained: empty got %b want 1", bus.empty); end
  endtask

  task automatic test_conflict;
    @(negedge clk);
    set_load(1'b1, 32'h900, 2'b10);
    set_store(1'b1, 32'h300, 32'hCAFEF00D, 2'b10);
    @(negedge clk);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    set_load(1'b1, 32'h304, 2'b00);
    #1;
    n_checks++; if ({bus.fwd_hit, bus.ld_conflict} !== 2'b00) begin n_fail++; $display("FAIL conflict_adjacent_above: got %b want 00", {bus.fwd_hit, bus.ld_conflict}); end
    set_load(1'b1, 32'h2FF, 2'b01);
    #1;
    n_checks++; if (bus.ld_conflict !== 1'b1) begin n_fail++; $display("FAIL conflict_straddle_below: got %b want 1", bus.ld_conflict); end
    set_load(1'b1, 32'h302, 2'b00);
    #1;
    n_checks++; if ({bus.ld_conflict, bus.fwd_hit, bus.mem_wr_en} !== 3'b101 || bus.mem_addr !== 32'h300)
      begin n_fail++; $display("FAIL conflict_drain: got %b addr %h want 101 addr 300", {bus.ld_conflict, bus.fwd_hit, bus.mem_wr_en}, bus.mem_addr); end
    @(negedge clk); #1;
    n_checks++; if ({bus.ld_conflict, bus.fwd_hit, bus.empty} !== 3'b001) begin n_fail++; $display("FAIL conflict_cleared: got %b want 001", {bus.ld_conflict, bus.fwd_hit, bus.empty}); end
    set_load(1'b0, 32'h0, 2'b00);
  endtask

  task automatic test_youngest;
    @(negedge clk);
    set_load(1'b1, 32'h900, 2'b10);
    set_store(1'b1, 32'h400, 32'h11111111, 2'b10);
    @(negedge clk);
    set_store(1'b1, 32'h400, 32'h22222222, 2'b10);
    @(negedge clk);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    set_load(1'b1, 32'h400, 2'b10);
    #1;
    n_checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h22222222) begin n_fail++; $display("FAIL youngest_word: got hit=%b %h want 1 22222222", bus.fwd_hit, bus.fwd_data); end
    set_load(1'b1, 32'h900, 2'b10);
    set_store(1'b1, 32'h401, 32'h33, 2'b00);
    @(negedge clk);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    set_load(1'b1, 32'h401, 2'b00);
    #1;
    n_checks++; if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h00000033) begin n_fail++; $display("FAIL youngest_byte_hit: got hit=%b %h want 1 00000033", bus.fwd_hit, bus.fwd_data); end
    set_load(1'b1, 32'h400, 2'b10);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({bus.ld_conflict, bus.fwd_hit, bus.mem_wr_en} !== 3'b101 || bus.mem_addr !== ((i == 2) ? 32'h401 : 32'h400))
        begin n_fail++; $display("FAIL youngest_conflict_%0d: got %b addr %h want 101 addr %h", i, {bus.ld_conflict, bus.fwd_hit, bus.mem_wr_en}, bus.mem_addr, (i == 2) ? 32'h401 : 32'h400); end
      @(negedge clk);
    end
    #1;
    n_checks++; if ({bus.ld_conflict, bus.fwd_hit, bus.empty} !== 3'b001) begin n_fail++; $display("FAIL youngest_cleared: got %b want 001", {bus.ld_conflict, bus.fwd_hit, bus.empty}); end
    set_load(1'b0, 32'h0, 2'b00);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    set_load(1'b0, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h500 + 32'(4*i), 32'hA0 + 32'(i), 2'b10);
      @(negedge clk);
      #1;
      n_checks++; if ({bus.st_ready, bus.empty, bus.mem_wr_en} !== 3'b101 || bus.mem_addr !== 32'h500 + 32'(4*i) || bus.mem_wr_data !== 32'hA0 + 32'(i))
        begin n_fail++; $display("FAIL b2b_%0d: got %b %h %h want 101 %h %h", i, {bus.st_ready, bus.empty, bus.mem_wr_en}, bus.mem_addr, bus.mem_wr_data, 32'h500 + 32'(4*i), 32'hA0 + 32'(i)); end
    end
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk); #1;
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_mid_drain;
    @(negedge clk);
    set_load(1'b1, 32'h900, 2'b10);
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h600 + 32'(4*i), 32'h77 + 32'(i), 2'b10);
      @(negedge clk);
    end
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    set_load(1'b0, 32'h0, 2'b00);
    #1;
    n_checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 32'h600) begin n_fail++; $display("FAIL rst_mid_pre: got en=%b %h want 1 600", bus.mem_wr_en, bus.mem_addr); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if ({bus.empty, bus.st_ready, bus.mem_wr_en} !== 3'b110 || bus.mem_addr !== 32'h0 || bus.mem_wr_data !== 32'h0)
      begin n_fail++; $display("FAIL rst_mid_immediate: got %b %h %h want 110 0 0", {bus.empty, bus.st_ready, bus.mem_wr_en}, bus.mem_addr, bus.mem_wr_data); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({bus.mem_wr_en, bus.empty} !== 2'b01) begin n_fail++; $display("FAIL rst_mid_after_%0d: got %b want 01", i, {bus.mem_wr_en, bus.empty}); end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    set_load(1'b0, 32'h0, 2'b00);
    set_store(1'b0, 32'h0, 32'h0, 2'b00);
    #1 rst = 1'b1;
    test_reset();
    test_push_drain();
    test_fill();
    test_illegal_size();
    test_forward();
    test_conflict();
    test_youngest();
    test_back_to_back();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
